// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core.
// Owns the PC, issues imem requests and applies the decode-stage PC select (no delay slot).
module fetch_stage #(
  parameter int unsigned              ADDR_W   = 32,
  parameter logic        [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [1:0]        pcsrc,
  input  logic [31:0]       rs_data,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ready,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc4,
  output logic [5:0]        id_opcode,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [5:0]        id_func
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] target;
  logic [31:0]       branch_off;
  logic [31:0]       skid;
  logic              redirect;
  logic              fetch_done;

  assign pc_plus4   = pc + ADDR_W'(4);
  assign branch_off = {{14{id_instr[15]}}, id_instr[15:0], 2'b00};

  // pcsrc is only meaningful for a real instruction sitting in ID.
  assign redirect   = id_valid && (pcsrc != 2'b00) && !stall;
  assign fetch_done = (state == S_REQ) && imem_ready;

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    target = id_pc4;
    case (pcsrc)
      2'b01:   target = id_pc4 + branch_off;
      2'b10:   target = {id_pc4[ADDR_W-1:ADDR_W-4], id_instr[25:0], 2'b00};
      2'b11:   target = rs_data & 32'hFFFF_FFFC;
      default: target = id_pc4;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      skid     <= '0;
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc4   <= '0;
    end else if (stall) begin
      // PC and IF/ID frozen; a fetch finishing now parks in the skid buffer.
      if (state == S_IDLE) begin
        state <= S_REQ;
      end else if (fetch_done) begin
        skid  <= imem_rdata;
        state <= S_HOLD;
      end
    end else if (redirect) begin
      // Wrong-path word (in flight or parked) is dropped; one bubble enters ID.
      pc       <= target;
      id_valid <= 1'b0;
      skid     <= '0;
      state    <= S_REQ;
    end else if (fetch_done || (state == S_HOLD)) begin
      id_instr <= (state == S_HOLD) ? skid : imem_rdata;
      id_pc4   <= pc_plus4;
      id_valid <= 1'b1;
      pc       <= pc_plus4;
      state    <= S_REQ;
    end else begin
      id_valid <= 1'b0;
      state    <= S_REQ;
    end
  end

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;

  assign id_opcode = id_instr[31:26];
  assign id_rs     = id_instr[25:21];
  assign id_rt     = id_instr[20:16];
  assign id_func   = id_instr[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: directed stimulus pushes the expected IF/ID words,
// a monitor pops and compares each newly latched instruction.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [1:0]  pcsrc;
  logic [31:0] rs_data;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [5:0]  id_func;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [31:0] BEQ_FWD  = 32'h1022_0003;  // beq $1,$2,+3
  localparam logic [31:0] BEQ_BACK = 32'h1000_FFFE;  // beq $0,$0,-2
  localparam logic [31:0] JR_R8    = 32'h0100_0008;  // jr $8
  localparam logic [31:0] J_WORD   = 32'h0800_0040;  // j, target field 0x40

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .pcsrc      (pcsrc),
    .rs_data    (rs_data),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc4     (id_pc4),
    .id_opcode  (id_opcode),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_func    (id_func)
  );

  // Instruction memory: word equals its address unless a control-flow word lives there.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0020:                              return BEQ_FWD;
      32'h0000_0034, 32'h8000_0100, 32'h0000_1000: return JR_R8;
      32'h8000_0000:                              return J_WORD;
      32'hFFFF_FFFC:                              return BEQ_BACK;
      default:                                    return a;
    endcase
  endfunction

  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc4);
    exp_q.push_back({instr, pc4});
  endtask

  // A new word enters IF/ID on any edge out of reset, without stall, that leaves id_valid high.
  initial begin : monitor
    logic st;
    exp_t e;
    forever begin
      @(posedge clk);
      st = stall;
      #1;
      if (rst && id_valid && !st) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got instr=%h pc4=%h, expected no new word", id_instr, id_pc4);
        end else begin
          e = exp_q.pop_front();
          check("sb_id_word", {id_instr, id_pc4}, {e.instr, e.pc4});
        end
      end
    end
  end

  initial begin : stimulus
    rst        = 1'b0;
    stall      = 1'b0;
    pcsrc      = 2'b00;
    rs_data    = 32'h0;
    imem_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_req",   imem_req,  0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_valid", id_valid,  0);
    check("rst_instr", id_instr,  32'h0);
    check("rst_pc4",   id_pc4,    32'h0);
    @(negedge clk);
    rst = 1'b1;
    push(32'h0, 32'h4);
    push(32'h4, 32'h8);
    push(32'h8, 32'hC);

    // Zero-wait streaming
    @(negedge clk);
    check("t1_req_rise", imem_req,  1);
    check("t1_addr0",    imem_addr, 32'h0);
    check("t1_idle_bub", id_valid,  0);
    repeat (3) begin
      @(negedge clk);
      check("t1_valid", id_valid, 1);
    end

    // Two wait states
    imem_ready = 1'b0;
    push(32'hC, 32'h10);
    repeat (2) begin
      @(negedge clk);
      check("t2_bubble",  id_valid,  0);
      check("t2_pc_held", imem_addr, 32'hC);
    end
    imem_ready = 1'b1;
    @(negedge clk);
    check("t2_valid",  id_valid,  1);
    check("t2_pc_adv", imem_addr, 32'h10);

    // Fetch of 0x10 completes under stall and is released from the skid buffer
    stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t3_req_low",  imem_req,  0);
      check("t3_pc_held",  imem_addr, 32'h10);
      check("t3_valid",    id_valid,  1);
      check("t3_instr",    id_instr,  32'hC);
      check("t3_pc4",      id_pc4,    32'h10);
      imem_ready = 1'b0;
    end
    stall = 1'b0;
    push(32'h10, 32'h14);
    @(negedge clk);
    check("t3_rel_valid", id_valid,  1);
    check("t3_rel_addr",  imem_addr, 32'h14);
    check("t3_rel_req",   imem_req,  1);
    imem_ready = 1'b1;

    // Forward beq at 0x20
    push(32'h14, 32'h18);
    push(32'h18, 32'h1C);
    push(32'h1C, 32'h20);
    push(BEQ_FWD, 32'h24);
    repeat (4) @(negedge clk);
    check("t4_opcode", id_opcode, 6'd4);
    check("t4_rs",     id_rs,     5'd1);
    check("t4_rt",     id_rt,     5'd2);
    pcsrc = 2'b01;
    @(negedge clk);
    check("t4_flush",  id_valid,  0);
    check("t4_target", imem_addr, 32'h30);
    pcsrc = 2'b00;
    push(32'h30, 32'h34);
    @(negedge clk);
    check("t4_one_bubble", id_valid, 1);

    // jr to 0x8000_0003 (low bits masked), then j, then jr to 0x1003
    push(JR_R8, 32'h38);
    @(negedge clk);
    check("t5_func", id_func, 6'd8);
    check("t5_rs",   id_rs,   5'd8);
    pcsrc   = 2'b11;
    rs_data = 32'h8000_0003;
    @(negedge clk);
    check("t5_jr_hi",    imem_addr, 32'h8000_0000);
    check("t5_jr_flush", id_valid,  0);
    pcsrc = 2'b00;
    push(J_WORD, 32'h8000_0004);
    @(negedge clk);
    check("t5_j_opcode", id_opcode, 6'd2);
    pcsrc = 2'b10;
    @(negedge clk);
    check("t5_j_target", imem_addr, 32'h8000_0100);
    pcsrc = 2'b00;
    push(JR_R8, 32'h8000_0104);
    @(negedge clk);
    pcsrc   = 2'b11;
    rs_data = 32'h0000_1003;
    @(negedge clk);
    check("t5_jr_target", imem_addr, 32'h0000_1000);
    pcsrc = 2'b00;

    // Stall outranks a redirect; the parked wrong-path word is then discarded
    push(JR_R8, 32'h1004);
    @(negedge clk);
    stall   = 1'b1;
    pcsrc   = 2'b11;
    rs_data = 32'hFFFF_FFFF;
    @(negedge clk);
    check("t5_stall_pc",  imem_addr, 32'h1004);
    check("t5_stall_req", imem_req,  0);
    check("t5_stall_vld", id_valid,  1);
    check("t5_stall_pc4", id_pc4,    32'h1004);
    stall = 1'b0;
    @(negedge clk);
    check("t5_redir_addr", imem_addr, 32'hFFFF_FFFC);
    check("t5_redir_vld",  id_valid,  0);
    check("t5_redir_req",  imem_req,  1);
    pcsrc = 2'b00;

    // Wrap at the top of the address space, then a backward branch across it
    push(BEQ_BACK, 32'h0);
    @(negedge clk);
    check("wrap_pc", imem_addr, 32'h0);
    pcsrc = 2'b01;
    @(negedge clk);
    check("back_target", imem_addr, 32'hFFFF_FFF8);
    pcsrc = 2'b00;
    push(32'hFFFF_FFF8, 32'hFFFF_FFFC);
    @(negedge clk);
    check("back_valid", id_valid, 1);

    // Reset with an outstanding request
    imem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6a_valid", id_valid,  0);
    check("t6a_addr",  imem_addr, 32'h0);
    check("t6a_req",   imem_req,  0);
    check("t6a_instr", id_instr,  32'h0);
    check("t6a_pc4",   id_pc4,    32'h0);
    @(negedge clk);
    rst        = 1'b1;
    imem_ready = 1'b1;
    push(32'h0, 32'h4);
    repeat (2) @(negedge clk);
    check("t6a_first_vld", id_valid,  1);
    check("t6a_next_addr", imem_addr, 32'h4);

    // Reset while a word sits in the skid buffer
    stall = 1'b1;
    @(negedge clk);
    check("t6b_hold_req", imem_req, 0);
    rst = 1'b0;
    #1;
    check("t6b_valid", id_valid,  0);
    check("t6b_addr",  imem_addr, 32'h0);
    check("t6b_req",   imem_req,  0);
    stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    push(32'h0, 32'h4);
    @(negedge clk);
    check("t6b_req_rise", imem_req,  1);
    check("t6b_addr0",    imem_addr, 32'h0);
    @(negedge clk);
    check("t6b_first_vld", id_valid, 1);
    imem_ready = 1'b0;
    repeat (2) @(negedge clk);

    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
